// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one uart_tx among NUM_REQ byte streams
// Ports: clk, n_reset (sync, active-low); req/req_data/req_last/req_ack per requester;
//   grant one-hot packet owner; tx_start_write/tx_write_data/tx_write_avl to uart_tx;
//   busy (not idle); timeout_err sticky when write_avl never falls after a start_write.
// Optional: define UART_ARB_HDR_EN to prefix each packet with header byte {4'hA, grant index}.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start_write,
  output logic [7:0]           tx_write_data,
  input  logic                 tx_write_avl,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, g_idx, sel, g_nxt;
  logic [CW-1:0] cnt;
  logic last_q;
`ifdef UART_ARB_HDR_EN
  logic hdr_q;
`endif
  // lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall
  always_comb begin
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i]) sel = IW'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i] && IW'(i) >= rr_ptr) sel = IW'(i);
  end
  assign g_nxt = (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      g_idx <= '0;
      grant <= '0;
      req_ack <= '0;
      tx_start_write <= 1'b0;
      tx_write_data <= '0;
      timeout_err <= 1'b0;
      last_q <= 1'b0;
      cnt <= '0;
`ifdef UART_ARB_HDR_EN
      hdr_q <= 1'b0;
`endif
    end else begin
      tx_start_write <= 1'b0;
      req_ack <= '0;
      case (state)
        IDLE: if (|req) begin
          g_idx <= sel;
          grant <= NUM_REQ'(1) << sel;
          state <= LOAD;
`ifdef UART_ARB_HDR_EN
          hdr_q <= 1'b1;
`endif
        end
        LOAD: if (!req[g_idx]) begin
          grant <= '0;
          rr_ptr <= g_nxt;
          state <= IDLE;
        end else if (tx_write_avl) begin
          tx_start_write <= 1'b1;
          tx_write_data <= req_data[{g_idx, 3'b000} +: 8];
          last_q <= req_last[g_idx];
          req_ack <= NUM_REQ'(1) << g_idx;
          cnt <= '0;
          state <= WAIT_BUSY;
`ifdef UART_ARB_HDR_EN
          // header goes out first; the payload byte stays pending without an ack
          if (hdr_q) begin
            tx_write_data <= {4'hA, 4'(g_idx)};
            last_q <= 1'b0;
            req_ack <= '0;
            hdr_q <= 1'b0;
          end
`endif
        end
        WAIT_BUSY: if (!tx_write_avl) state <= WAIT_DONE;
        else begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            grant <= '0;
            rr_ptr <= g_nxt;
            state <= IDLE;
          end
        end
        WAIT_DONE: if (tx_write_avl) begin
          if (last_q) begin
            grant <= '0;
            rr_ptr <= g_nxt;
            state <= IDLE;
          end else state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized self-checking bench with a packet-level arbitration model
module tb_uart_tx_arbiter;
  localparam int NUM = 4;
`ifdef UART_ARB_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  typedef struct {bit hdr; int idx; logic [7:0] d;} ent_t;
  logic clk = 1'b0, n_reset = 1'b0;
  logic [NUM-1:0] req = '0, req_last = '0, en = '1, req_ack, grant;
  logic [8*NUM-1:0] req_data = '0;
  logic tx_start_write, tx_write_avl, busy, timeout_err;
  logic [7:0] tx_write_data;
  logic avl_m = 1'b1, stuck = 1'b0, free = 1'b0, prev_start = 1'b0;
  int checks = 0, errors = 0, cyc = 0, ack_cnt = 0, start_cnt = 0, bc = 0;
  logic [31:0] ord = '0, pay = '0;
  logic [7:0] first_byte = '0;
  logic [8:0] rq [NUM][$];
  ent_t exp_q[$];
  ent_t e;
  assign tx_write_avl = avl_m | stuck;
  uart_tx_arbiter #(.NUM_REQ(NUM), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .n_reset(n_reset), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .tx_start_write(tx_start_write),
    .tx_write_data(tx_write_data), .tx_write_avl(tx_write_avl), .busy(busy),
    .timeout_err(timeout_err)
  );
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic int idx_of(input logic [NUM-1:0] v);
    for (int i = 0; i < NUM; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic push(input int i, input logic [8:0] b);
    rq[i].push_back(b);
  endtask
  // Packet-level reference: round robin from p among requesters in mask m that have
  // queued bytes; each grant carries one packet (up to the last flag or queue end).
  task automatic build_exp(input int p, input logic [NUM-1:0] m, output int pn);
    logic [8:0] c [NUM][$];
    logic [8:0] b;
    int f;
    for (int i = 0; i < NUM; i++) c[i] = rq[i];
    while (1) begin
      f = -1;
      for (int k = 0; k < NUM; k++)
        if (f < 0 && m[(p + k) % NUM] && c[(p + k) % NUM].size() != 0) f = (p + k) % NUM;
      if (f < 0) break;
      if (HDR != 0) exp_q.push_back('{1'b1, f, {4'hA, 4'(f)}});
      do begin
        b = c[f].pop_front();
        exp_q.push_back('{1'b0, f, b[7:0]});
      end while (!b[8] && c[f].size() != 0);
      p = (f + 1) % NUM;
    end
    pn = p;
  endtask
  // uart_tx model: write_avl drops right after a start_write and returns after a random time
  initial forever begin
    @(negedge clk);
    if (!n_reset) begin
      avl_m = 1'b1;
      bc = 0;
    end else if (bc > 0) begin
      bc--;
      if (bc == 0) avl_m = 1'b1;
    end else if (tx_start_write && !stuck) begin
      avl_m = 1'b0;
      bc = $urandom_range(1, 5);
    end
  end
  // requesters: present queue head, advance on ack, drop req when empty
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NUM; i++) begin
      if (req_ack[i] && rq[i].size() != 0) rq[i].delete(0);
      req[i] = en[i] && rq[i].size() != 0;
      req_data[8*i +: 8] = rq[i].size() != 0 ? rq[i][0][7:0] : 8'h00;
      req_last[i] = rq[i].size() != 0 ? rq[i][0][8] : 1'b0;
    end
  end
  // compare process: invariants every cycle, wire bytes against the model on each start_write
  initial forever begin
    @(negedge clk);
    if (n_reset) begin
      check("grant_onehot", 32'($onehot0(grant)), 1);
      check("ack_onehot", 32'($onehot0(req_ack)), 1);
      check("busy_vs_grant", 32'(busy), 32'(|grant));
      check("start_back_to_back", 32'(prev_start & tx_start_write), 0);
      check("ack_without_start", 32'(|req_ack & !tx_start_write), 0);
      if (tx_start_write) begin
        if (start_cnt == 0) first_byte = tx_write_data;
        start_cnt++;
        if (!free) begin
          if (exp_q.size() == 0) check("start_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("wire_byte", 32'(tx_write_data), 32'(e.d));
            check("issue_grant", 32'(grant), 32'(1 << e.idx));
            check("issue_ack", 32'(req_ack), e.hdr ? 0 : 32'(1 << e.idx));
          end
        end
      end
      if (req_ack != 0) begin
        ack_cnt++;
        ord = (ord << 4) | 32'(idx_of(req_ack));
        pay = (pay << 8) | 32'(tx_write_data);
      end
    end
    prev_start = n_reset & tx_start_write;
  end
  task automatic do_reset();
    n_reset = 1'b0;
    for (int i = 0; i < NUM; i++) rq[i].delete();
    exp_q.delete();
    en = '1;
    free = 1'b0;
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    ack_cnt = 0;
    start_cnt = 0;
    ord = '0;
    pay = '0;
    first_byte = '0;
  endtask
  task automatic wait_done(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (n < budget && !(exp_q.size() == 0 && !busy && req == '0)) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 1);
  endtask
  task automatic wait_ack(input string name);
    int n = 0;
    while (ack_cnt < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(ack_cnt >= 1), 1);
  endtask
  initial begin
    int p, n, t0, np, len;
    logic lst;
    do_reset();
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(req_ack), 0);
    check("rst_start", 32'(tx_start_write), 0);
    check("rst_data", 32'(tx_write_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    // single requester, 3-byte packet
    push(1, 9'h011); push(1, 9'h022); push(1, 9'h133);
    build_exp(0, '1, p);
    wait_done("p1_done", 400);
    check("p1_payload", pay, 32'h112233);
    check("p1_acks", 32'(ack_cnt), 3);
    check("p1_starts", 32'(start_cnt), 32'(3 + HDR));
    // all four requesting 1-byte packets, requester 0 twice
    do_reset();
    push(0, 9'h1A0); push(0, 9'h1B0); push(1, 9'h1A1); push(2, 9'h1A2); push(3, 9'h1A3);
    build_exp(0, '1, p);
    wait_done("p2_done", 600);
    check("p2_order", ord, 32'h01230);
    check("p2_acks", 32'(ack_cnt), 5);
    // requester 0 rises while requester 2's packet is in flight
    do_reset();
    en = 4'b1110;
    push(2, 9'h031); push(2, 9'h032); push(2, 9'h033); push(2, 9'h134); push(0, 9'h1C0);
    build_exp(0, 4'b0100, p);
    build_exp(p, 4'b0001, p);
    wait_ack("p3_first_ack");
    en[0] = 1'b1;
    wait_done("p3_done", 600);
    check("p3_order", ord, 32'h22220);
    // write_avl stuck high
    do_reset();
    stuck = 1'b1;
    free = 1'b1;
    push(1, 9'h144);
    n = 0;
    while (!tx_start_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_start_seen", 32'(tx_start_write), 1);
    t0 = cyc;
    n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", 32'(cyc - t0), 16);
    check("to_grant_clear", 32'(grant), 0);
    check("to_idle", 32'(busy), 0);
    repeat (10) @(negedge clk);
    check("to_sticky", 32'(timeout_err), 1);
    do_reset();
    check("to_cleared", 32'(timeout_err), 0);
    // abandoned packet on requester 3, then arbitration from the advanced pointer
    push(3, 9'h077);
    build_exp(0, '1, p);
    wait_done("ab_done", 200);
    check("ab_acks", 32'(ack_cnt), 1);
    check("ab_starts", 32'(start_cnt), 32'(1 + HDR));
    check("ab_grant", 32'(grant), 0);
    push(2, 9'h102); push(0, 9'h101);
    build_exp(p, '1, p);
    wait_done("ab_next_done", 300);
    check("ab_order", ord, 32'h302);
    // single-byte packet on requester 2: first wire byte
    do_reset();
    push(2, 9'h15A);
    build_exp(0, '1, p);
    wait_done("hdr_done", 200);
    check("hdr_first_byte", 32'(first_byte), HDR != 0 ? 32'hA2 : 32'h5A);
    check("hdr_acks", 32'(ack_cnt), 1);
    check("hdr_starts", 32'(start_cnt), 32'(1 + HDR));
    // reset in the middle of a packet
    do_reset();
    push(1, 9'h0E1); push(1, 9'h0E2); push(1, 9'h1E3);
    build_exp(0, '1, p);
    wait_ack("mid_first_ack");
    n_reset = 1'b0;
    @(negedge clk);
    check("mid_grant", 32'(grant), 0);
    check("mid_start", 32'(tx_start_write), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_ack", 32'(req_ack), 0);
    // randomized traffic
    repeat (25) begin
      do_reset();
      for (int i = 0; i < NUM; i++) begin
        np = $urandom_range(0, 2);
        for (int k = 0; k < np; k++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            lst = (b == len - 1) && !(k == np - 1 && $urandom_range(0, 7) == 0);
            push(i, {lst, 8'($urandom)});
          end
        end
      end
      build_exp(0, '1, p);
      wait_done("rand_done", 3000);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single uart_tx transmitter among NUM_REQ independent byte-stream requesters.
- Arbitrates round-robin at packet granularity and sequences the uart_tx start_write / write_avl handshake one byte at a time.
- A grant is held for a whole packet, so bytes from different requesters never interleave on the wire.
- Sits between internal producers (debug dump, trace, command responses) and the uart_tx instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- TIMEOUT_CYCLES, 16, maximum number of cycles to wait for write_avl to fall after a start_write pulse.

Ports:
- clk  in  1  system clock
- n_reset  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester request; held high while the requester has a byte to send
- req_data  in  8*NUM_REQ  packed byte per requester; requester i owns bits [8i+7:8i]
- req_last  in  NUM_REQ  qualifies the current byte as the last byte of the packet
- req_ack  out  NUM_REQ  one-cycle pulse; byte consumed, requester may present its next byte
- grant  out  NUM_REQ  one-hot; identifies the current packet owner
- tx_start_write  out  1  connects to uart_tx start_write
- tx_write_data  out  8  connects to uart_tx write_data
- tx_write_avl  in  1  connects to uart_tx write_avl
- busy  out  1  high whenever state is not IDLE
- timeout_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr 0; timeout counter 0.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If req is nonzero, select the first requester at or above rr_ptr, wrapping modulo NUM_REQ.
  - Register grant one-hot and go to LOAD.
  - If req is zero, remain in IDLE.
- LOAD (g = granted index):
  - If req[g]=1 and tx_write_avl=1:
    - latch req_data[g] into tx_write_data;
    - pulse tx_start_write for exactly 1 cycle;
    - pulse req_ack[g] in the same cycle;
    - store req_last[g] in last_q;
    - clear the timeout counter and go to WAIT_BUSY.
  - If req[g]=1 and tx_write_avl=0: stay in LOAD.
  - If req[g]=0 (packet abandoned): clear grant, set rr_ptr = g+1 mod NUM_REQ, go to IDLE. No error is raised.
- WAIT_BUSY:
  - tx_start_write=0 and tx_write_data is held stable.
  - If tx_write_avl=0, go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES: set timeout_err, clear grant, advance rr_ptr, go to IDLE.
- WAIT_DONE:
  - Wait for tx_write_avl=1. There is no timeout in this state.
  - If last_q=1: clear grant, set rr_ptr = g+1 mod NUM_REQ, go to IDLE.
  - If last_q=0: go to LOAD.
- Latency: req rises, sampled in IDLE at edge k → grant valid after edge k → tx_start_write valid after edge k+1 (when avl=1).
- Back-to-back bytes: there is at least one idle cycle between the end of WAIT_DONE and the next start_write.
- Fairness: a requester that just finished a packet has lowest priority in the next arbitration.
- Simultaneous requests: priority ordering is rotated from rr_ptr; the losing requests stay pending, with no acks and unchanged data.
- req_data/req_last are sampled only in the LOAD issue cycle. A requester must hold them stable until its req_ack.
- At most one bit of req_ack and of grant is high in any cycle. tx_start_write is never high in two consecutive cycles.
- Reset mid-packet: outputs clear the following cycle. The uart_tx instance shares n_reset and aborts in step.
- tx_write_avl stuck high (uart_tx held in reset): timeout path is taken once per attempt, and arbitration continues.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- Defined:
  - At each packet start, LOAD first issues a header byte {4'hA, g[3:0]} without asserting req_ack.
  - The header passes through WAIT_BUSY/WAIT_DONE with last_q forced to 0, then payload bytes follow as normal.
  - An abandoned packet after the header still releases the grant with no trailer.
- Undefined: only payload bytes are sent; no header logic is present.

Test Plan:
- Single requester, 3-byte packet 0x11,0x22,0x33(last) on req[1], with a behavioural uart_tx → three start_write pulses carrying those values in order; three req_ack[1] pulses; grant=4'b0010 throughout; busy falls after the third write_avl rise.
- req=4'b1111 all held, 1-byte packets, rr_ptr=0 → grant order 0,1,2,3,0; no two packets interleaved.
- req[2] multi-byte packet in flight while req[0] rises → req[0] gets no ack until req[2]'s last byte completes; then grant=4'b0001.
- tx_write_avl tied 1 → timeout_err=1 exactly TIMEOUT_CYCLES=16 cycles after the start_write pulse; state returns to IDLE; flag stays 1 until n_reset.
- req[3] drops in LOAD mid-packet → grant clears next cycle; rr_ptr=0; no extra start_write.
- UART_ARB_HDR_EN defined, req[2] sends 0x5A(last) → wire bytes 0xA2 then 0x5A; exactly one req_ack[2] pulse.
